// File: rtl/mips_multicycle_control.sv
// Purpose : multicycle MIPS control FSM; decodes opcode/funct into datapath controls.
// Latency : Moore outputs follow state; lw 5, sw/R-type/addi 4, branch/jump 3 cycles (mem_ready=1).
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0 (when MEM_HANDSHAKE=1).
//
// Ports:
//   clock, reset (async active-low)       - state register clock and reset
//   opcode, funct                         - instruction register fields [31:26] and [5:0]
//   zero                                  - ALU zero flag, used by beq/bne
//   mem_ready                             - shared memory access completes this cycle
//   pc_we, IorD, MemRead, MemWrite,       - datapath enables and mux selects
//   IRWrite, MemtoReg, RegWrite, ALUSrcA,
//   isJAL, RegDst, ALUSrcB, PCSource, ALUOp
//   state                                 - current FSM state (debug)
//   instr_done                            - pulse in an instruction's final cycle
//   illegal                               - pulse in DECODE for an undecoded opcode
module mips_multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       isJAL,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_LDWB   = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JAL    = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;

    // With the handshake disabled every memory access completes in one cycle.
    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state   = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_we      = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        isJAL      = 1'b0;
        RegDst     = 2'b00;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUOp      = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is written together with the IR, only when the read lands.
                MemRead  = 1'b1;
                ALUSrcB  = 2'b01;
                ALUOp    = ALU_ADD;
                PCSource = 2'b00;
                IRWrite  = mem_rdy;
                pc_we    = mem_rdy;
                state_d  = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = (funct == FN_JR) ? S_JR : S_REXEC;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_JAL) begin
                    state_d = S_JAL;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_IEXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_rdy ? S_LDWB : S_MEMRD;
            end
            S_LDWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                RegDst     = 2'b00;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_rdy;
                state_d    = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = ALU_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                // bne is the only branch opcode with bit 0 set; it takes the
                // inverted zero flag.
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUOp      = ALU_SUB;
                PCSource   = 2'b01;
                pc_we      = (opcode == OP_BNE) ? ~zero : zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_we      = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, which is the link value for $31.
                pc_we      = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                isJAL      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b00;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_we      = 1'b1;
                PCSource   = 2'b11;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unused codes 14/15 recover to FETCH with all outputs idle.
                state_d = S_FETCH;
            end
        endcase

        // The state register already sits in FETCH during reset; only the
        // mem_ready-dependent FETCH enables need masking.
        if (!reset) begin
            pc_we   = 1'b0;
            IRWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Purpose : directed self-checking bench for mips_multicycle_control.
// Latency : per-cycle check of state and the full output vector.
// Backpressure: exercises mem_ready stalls in FETCH, MEMWR and MEMRD.
module tb_mips_multicycle_control;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, isJAL;
    logic [1:0] RegDst, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic       instr_done, illegal;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .isJAL      (isJAL),
        .RegDst     (RegDst),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {pc_we,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,isJAL,
    //  RegDst,ALUSrcB,PCSource,ALUOp,instr_done,illegal}
    logic [19:0] outs;
    assign outs = {pc_we, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, isJAL,
                   RegDst, ALUSrcB, PCSource, ALUOp, instr_done, illegal};

    localparam logic [19:0] F_R   = {9'b101010000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] F_W   = {9'b001000000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] DEC   = {9'b000000000, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] DEC_I = {9'b000000000, 2'b00, 2'b11, 2'b00, 3'b000, 2'b01};
    localparam logic [19:0] MADR  = {9'b000000010, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] MRD   = {9'b011000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] LDWB  = {9'b000001100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [19:0] MWR_W = {9'b010100000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] MWR_D = {9'b010100000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [19:0] REX   = {9'b000000010, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00};
    localparam logic [19:0] RWB   = {9'b000000100, 2'b01, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [19:0] BR_T  = {9'b100000010, 2'b00, 2'b00, 2'b01, 3'b001, 2'b10};
    localparam logic [19:0] BR_N  = {9'b000000010, 2'b00, 2'b00, 2'b01, 3'b001, 2'b10};
    localparam logic [19:0] JMP   = {9'b100000000, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10};
    localparam logic [19:0] JALO  = {9'b100000101, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10};
    localparam logic [19:0] JRO   = {9'b100000000, 2'b00, 2'b00, 2'b11, 3'b000, 2'b10};
    localparam logic [19:0] IEX   = {9'b000000010, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
    localparam logic [19:0] IWB   = {9'b000000100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] JOP = 6'b000010, JAL = 6'b000011, RT = 6'b000000, ADDI = 6'b001000;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [19:0] o;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input logic mr, input logic [3:0] st, input logic [19:0] o);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st; v.o = o;
        vecs.push_back(v);
    endfunction

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; opcode = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if (outs !== F_W) begin
            errors++; $display("FAIL reset_outs got %b want %b", outs, F_W);
        end
        @(posedge clock); #1;
        checks++;
        if (state !== 4'd0 || outs !== F_W) begin
            errors++; $display("FAIL reset_hold got st=%0d o=%b want st=0 o=%b", state, outs, F_W);
        end
    endtask

    task automatic test_lw();
        int done_cnt = 0;
        int rw_bad = 0;
        vecs.delete();
        push(LW, 6'd0, 1'b0, 1'b1, 4'd0, F_R);
        push(LW, 6'd0, 1'b0, 1'b1, 4'd1, DEC);
        push(LW, 6'd0, 1'b0, 1'b1, 4'd2, MADR);
        push(LW, 6'd0, 1'b0, 1'b1, 4'd3, MRD);
        push(LW, 6'd0, 1'b0, 1'b1, 4'd4, LDWB);
        push(LW, 6'd0, 1'b0, 1'b0, 4'd0, F_W);
        do_reset();
        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            checks++;
            if (state !== vecs[i].st) begin
                errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, vecs[i].st);
            end
            checks++;
            if (outs !== vecs[i].o) begin
                errors++; $display("FAIL lw_outs[%0d] got %b want %b", i, outs, vecs[i].o);
            end
            if (instr_done === 1'b1) done_cnt++;
            if (RegWrite === 1'b1 && state !== 4'd4) rw_bad++;
            @(negedge clock);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL lw_done_count got %0d want 1", done_cnt);
        end
        checks++;
        if (rw_bad !== 0) begin
            errors++; $display("FAIL lw_regwrite_outside_ldwb got %0d want 0", rw_bad);
        end
    endtask

    task automatic test_sw_wait();
        int mw_cnt = 0;
        int rw_cnt = 0;
        vecs.delete();
        push(SW, 6'd0, 1'b0, 1'b1, 4'd0, F_R);
        push(SW, 6'd0, 1'b0, 1'b1, 4'd1, DEC);
        push(SW, 6'd0, 1'b0, 1'b0, 4'd2, MADR);
        push(SW, 6'd0, 1'b0, 1'b0, 4'd5, MWR_W);
        push(SW, 6'd0, 1'b0, 1'b0, 4'd5, MWR_W);
        push(SW, 6'd0, 1'b0, 1'b0, 4'd5, MWR_W);
        push(SW, 6'd0, 1'b0, 1'b1, 4'd5, MWR_D);
        push(SW, 6'd0, 1'b0, 1'b0, 4'd0, F_W);
        do_reset();
        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            checks++;
            if (state !== vecs[i].st) begin
                errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, vecs[i].st);
            end
            checks++;
            if (outs !== vecs[i].o) begin
                errors++; $display("FAIL sw_outs[%0d] got %b want %b", i, outs, vecs[i].o);
            end
            if (MemWrite === 1'b1) mw_cnt++;
            if (RegWrite === 1'b1) rw_cnt++;
            @(negedge clock);
        end
        checks++;
        if (mw_cnt !== 4) begin
            errors++; $display("FAIL sw_memwrite_cycles got %0d want 4", mw_cnt);
        end
        checks++;
        if (rw_cnt !== 0) begin
            errors++; $display("FAIL sw_regwrite got %0d want 0", rw_cnt);
        end
    endtask

    task automatic test_branch();
        vecs.delete();
        push(BEQ, 6'd0, 1'b1, 1'b1, 4'd0, F_R);
        push(BEQ, 6'd0, 1'b1, 1'b1, 4'd1, DEC);
        push(BEQ, 6'd0, 1'b1, 1'b1, 4'd8, BR_T);
        push(BNE, 6'd0, 1'b1, 1'b1, 4'd0, F_R);
        push(BNE, 6'd0, 1'b1, 1'b1, 4'd1, DEC);
        push(BNE, 6'd0, 1'b1, 1'b1, 4'd8, BR_N);
        push(BNE, 6'd0, 1'b0, 1'b1, 4'd0, F_R);
        push(BNE, 6'd0, 1'b0, 1'b1, 4'd1, DEC);
        push(BNE, 6'd0, 1'b0, 1'b0, 4'd8, BR_T);
        push(BNE, 6'd0, 1'b0, 1'b0, 4'd0, F_W);
        do_reset();
        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            checks++;
            if (state !== vecs[i].st) begin
                errors++; $display("FAIL br_state[%0d] got %0d want %0d", i, state, vecs[i].st);
            end
            checks++;
            if (outs !== vecs[i].o) begin
                errors++; $display("FAIL br_outs[%0d] got %b want %b", i, outs, vecs[i].o);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_jumps();
        vecs.delete();
        push(JAL,  6'd0,      1'b0, 1'b1, 4'd0,  F_R);
        push(JAL,  6'd0,      1'b0, 1'b1, 4'd1,  DEC);
        push(JAL,  6'd0,      1'b0, 1'b1, 4'd10, JALO);
        push(RT,   6'b001000, 1'b0, 1'b1, 4'd0,  F_R);
        push(RT,   6'b001000, 1'b0, 1'b1, 4'd1,  DEC);
        push(RT,   6'b001000, 1'b0, 1'b1, 4'd13, JRO);
        push(RT,   6'b100000, 1'b0, 1'b1, 4'd0,  F_R);
        push(RT,   6'b100000, 1'b0, 1'b1, 4'd1,  DEC);
        push(RT,   6'b100000, 1'b0, 1'b1, 4'd6,  REX);
        push(RT,   6'b100000, 1'b0, 1'b1, 4'd7,  RWB);
        push(JOP,  6'd0,      1'b0, 1'b1, 4'd0,  F_R);
        push(JOP,  6'd0,      1'b0, 1'b1, 4'd1,  DEC);
        push(JOP,  6'd0,      1'b0, 1'b1, 4'd9,  JMP);
        push(ADDI, 6'd0,      1'b0, 1'b1, 4'd0,  F_R);
        push(ADDI, 6'd0,      1'b0, 1'b1, 4'd1,  DEC);
        push(ADDI, 6'd0,      1'b0, 1'b1, 4'd11, IEX);
        push(ADDI, 6'd0,      1'b0, 1'b1, 4'd12, IWB);
        push(ADDI, 6'd0,      1'b0, 1'b0, 4'd0,  F_W);
        push(ADDI, 6'd0,      1'b0, 1'b1, 4'd0,  F_R);
        push(ADDI, 6'd0,      1'b0, 1'b1, 4'd1,  DEC);
        do_reset();
        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            checks++;
            if (state !== vecs[i].st) begin
                errors++; $display("FAIL jmp_state[%0d] got %0d want %0d", i, state, vecs[i].st);
            end
            checks++;
            if (outs !== vecs[i].o) begin
                errors++; $display("FAIL jmp_outs[%0d] got %b want %b", i, outs, vecs[i].o);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_illegal();
        int ill_cnt = 0;
        vecs.delete();
        push(6'b111111, 6'd0, 1'b0, 1'b1, 4'd0, F_R);
        push(6'b111111, 6'd0, 1'b0, 1'b1, 4'd1, DEC_I);
        push(6'b111111, 6'd0, 1'b0, 1'b0, 4'd0, F_W);
        push(6'b111111, 6'd0, 1'b0, 1'b0, 4'd0, F_W);
        do_reset();
        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            checks++;
            if (state !== vecs[i].st) begin
                errors++; $display("FAIL ill_state[%0d] got %0d want %0d", i, state, vecs[i].st);
            end
            checks++;
            if (outs !== vecs[i].o) begin
                errors++; $display("FAIL ill_outs[%0d] got %b want %b", i, outs, vecs[i].o);
            end
            if (illegal === 1'b1) ill_cnt++;
            @(negedge clock);
        end
        checks++;
        if (ill_cnt !== 1) begin
            errors++; $display("FAIL ill_pulse_count got %0d want 1", ill_cnt);
        end
    endtask

    task automatic test_reset_midwait();
        int bad = 0;
        vecs.delete();
        push(LW, 6'd0, 1'b0, 1'b1, 4'd0, F_R);
        push(LW, 6'd0, 1'b0, 1'b1, 4'd1, DEC);
        push(LW, 6'd0, 1'b0, 1'b0, 4'd2, MADR);
        push(LW, 6'd0, 1'b0, 1'b0, 4'd3, MRD);
        push(LW, 6'd0, 1'b0, 1'b0, 4'd3, MRD);
        do_reset();
        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            checks++;
            if (state !== vecs[i].st) begin
                errors++; $display("FAIL rmid_state[%0d] got %0d want %0d", i, state, vecs[i].st);
            end
            checks++;
            if (outs !== vecs[i].o) begin
                errors++; $display("FAIL rmid_outs[%0d] got %b want %b", i, outs, vecs[i].o);
            end
            @(negedge clock);
        end
        // Mid-cycle assertion while MEMRD is still waiting.
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL rmid_async_state got %0d want 0", state);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== F_W) begin
            errors++; $display("FAIL rmid_reset_outs got %b want %b", outs, F_W);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (RegWrite === 1'b1 || MemWrite === 1'b1 || pc_we === 1'b1 || state !== 4'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rmid_abandon got %0d bad cycles want 0", bad);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || outs !== F_R) begin
            errors++; $display("FAIL rmid_resume_fetch got st=%0d o=%b want st=0 o=%b", state, outs, F_R);
        end
        @(negedge clock); #1;
        checks++;
        if (state !== 4'd1 || outs !== DEC) begin
            errors++; $display("FAIL rmid_resume_decode got st=%0d o=%b want st=1 o=%b", state, outs, DEC);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_midwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_HANDSHAKE, default 1: when 1, memory states wait for mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port opcode, input, 6, instruction register bits [31:26].
REQ-005 The block SHALL have port funct, input, 6, instruction register bits [5:0].
REQ-006 The block SHALL have port zero, input, 1, ALU zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1, shared memory access complete this cycle.
REQ-008 The block SHALL have these outputs, each 1 bit: pc_we (PC write enable), IorD (0 = address from PC, 1 = address from ALUOut), MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA (0 = PC, 1 = register A), isJAL (write data = PC).
REQ-009 The block SHALL have these outputs, each 2 bits: RegDst (00 rt, 01 rd, 10 $31), ALUSrcB (00 B, 01 const 4, 10 sign-ext, 11 sign-ext<<2), PCSource (00 ALU, 01 ALUOut, 10 jump target, 11 register A).
REQ-010 The block SHALL have output ALUOp, 3 bits: 000 add, 001 sub, 010 decode from funct.
REQ-011 The block SHALL have output state, 4 bits, the current FSM state for debug.
REQ-012 The block SHALL have output instr_done, 1 bit, one-cycle pulse in an instruction's final cycle.
REQ-013 The block SHALL have output illegal, 1 bit, one-cycle pulse when an opcode is not decoded.

Function
REQ-014 States SHALL be encoded as follows: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, LDWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, JAL=10, IEXEC=11, IWB=12, JR=13; codes 14 and 15 SHALL go to FETCH on the next edge.
REQ-015 All outputs SHALL be Moore decodes of state, except that pc_we, IRWrite and instr_done depend on mem_ready or zero as stated below; any output not listed for a state SHALL be 0.
REQ-016 In FETCH: MemRead=1, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite and pc_we SHALL equal mem_ready; FETCH SHALL hold until mem_ready=1, then go to DECODE.
REQ-017 In DECODE: ALUSrcB=11, ALUOp=000.
REQ-018 DECODE SHALL branch as follows: lw (100011) or sw (101011) -> MEMADR; R-type (000000) with funct 001000 -> JR; any other R-type -> REXEC; beq (000100) or bne (000101) -> BRANCH; j (000010) -> JUMP; jal (000011) -> JAL; addi (001000) -> IEXEC; any other opcode -> FETCH with illegal=1.
REQ-019 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=000, then go to MEMRD if the opcode is lw, or to MEMWR if it is sw.
REQ-020 MEMRD SHALL drive MemRead=1, IorD=1, hold until mem_ready=1, then go to LDWB.
REQ-021 LDWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=00, then go to FETCH.
REQ-022 MEMWR SHALL drive MemWrite=1, IorD=1, hold until mem_ready=1, then go to FETCH.
REQ-023 REXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=010, then go to RWB.
REQ-024 RWB SHALL drive RegWrite=1, RegDst=01, then go to FETCH.
REQ-025 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, with pc_we = zero for beq and pc_we = ~zero for bne, then go to FETCH.
REQ-026 JUMP SHALL drive pc_we=1, PCSource=10, then go to FETCH.
REQ-027 JAL SHALL drive pc_we=1, PCSource=10, RegWrite=1, RegDst=10, isJAL=1, then go to FETCH.
REQ-028 JR SHALL drive pc_we=1, PCSource=11, then go to FETCH.
REQ-029 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=000, then go to IWB.
REQ-030 IWB SHALL drive RegWrite=1, RegDst=00, then go to FETCH.
REQ-031 instr_done SHALL be 1 in every cycle whose next state is FETCH and that is not an illegal-opcode decode; in MEMWR it SHALL be gated by mem_ready.
REQ-032 MemRead and MemWrite SHALL never be 1 in the same cycle; pc_we SHALL be at most 1 per instruction outside FETCH.
REQ-033 Cycle counts with mem_ready constantly 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jal/jr 3.

Reset
REQ-034 While reset=0, state SHALL be FETCH asynchronously, and every output SHALL be 0 except those FETCH decodes: MemRead=1, ALUSrcB=01; pc_we and IRWrite SHALL be forced to 0 during reset.
REQ-035 Reset asserted mid-instruction, including during a mem_ready wait, SHALL abandon the instruction with no further RegWrite, MemWrite or pc_we pulse.
REQ-036 The first FETCH after reset release SHALL accept mem_ready on the first rising edge.

Verification
REQ-037 Test lw, mem_ready=1: reset release, opcode=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done pulses once.
REQ-038 Test sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 held for 4 cycles, then state 0; RegWrite is never 1.
REQ-039 Test beq with zero=1, then bne with zero=1 -> pc_we=1 in BRANCH for beq only; both return to FETCH after 3 cycles.
REQ-040 Test jal, then jr (opcode 000000, funct 001000) -> jal: RegDst=10, isJAL=1, pc_we=1, PCSource=10; jr: PCSource=11; R-type funct 100000 goes to REXEC instead.
REQ-041 Test opcode 111111 -> illegal pulses for 1 cycle in DECODE, next state FETCH, no RegWrite or MemWrite.
REQ-042 Test reset=0 asserted during MEMRD wait -> state=0 immediately; after release, normal fetch resumes.
